eth_phy_10g_rx_link_ctrl: RTL and testbench

This block is the 10GBASE-R receive link-bringup controller. It sits beside the RX block-lock and BER-monitor logic and turns their status into the decisions that bring the link up. It sequences SERDES RX reset requests, times out stalled lock acquisition, and qualifies link-up with a hold-off period. It exports a single `rx_status` link indication plus diagnostic counters.

---
 rtl/eth_phy_10g_pkg.sv | 15 +
 rtl/eth_phy_10g_tick_gen.sv | 32 +++
 rtl/eth_phy_10g_rx_link_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_eth_phy_10g_rx_link_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_phy_10g_pkg.sv
// Shared definitions for the 10GBASE-R PHY receive path: link FSM state encoding
// and the default 125 us prescaler length for a 6.4 ns clock.
package eth_phy_10g_pkg;

   typedef enum logic [2:0] {
      ST_DISABLED   = 3'd0,
      ST_SERDES_RST = 3'd1,
      ST_WAIT_LOCK  = 3'd2,
      ST_WAIT_BER   = 3'd3,
      ST_LINK_UP    = 3'd4
   } linkState_t;

   localparam int COUNT_125US_DEFAULT = 19531;

endpackage

// File: rtl/eth_phy_10g_tick_gen.sv
// Down-counting prescaler that pulses o_tick once per COUNT cycles; i_reload
// restarts the period so timing is measured from the last reload.
module eth_phy_10g_tick_gen
   import eth_phy_10g_pkg::*;
#(
   parameter int COUNT = COUNT_125US_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_reload,
   output logic o_tick
);

   localparam int CW = $clog2(COUNT + 1);
   localparam logic [CW-1:0] RELOAD_VAL = CW'(COUNT - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= RELOAD_VAL;
      end else if (i_reload || (r_count == '0)) begin
         r_count <= RELOAD_VAL;
      end else begin
         r_count <= r_count - 1'b1;
      end
   end

   // A tick coinciding with a reload belongs to the old period and is dropped.
   assign o_tick = (r_count == '0) && !i_reload;

endmodule

// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// 10GBASE-R receive link-bringup controller: SERDES reset sequencing, lock timeout
// and link-up hold-off. Errored-block counter enabled by ETH_PHY_RX_LINK_CTRL_ERR_CNT_EN.
module eth_phy_10g_rx_link_ctrl
   import eth_phy_10g_pkg::*;
#(
   parameter int COUNT_125US        = COUNT_125US_DEFAULT,
   parameter int RESET_PULSE_CYCLES = 16,
   parameter int LOCK_TIMEOUT_TICKS = 80,
   parameter int UP_HOLD_TICKS      = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_cfg_enable,
   input  logic        i_rx_block_lock,
   input  logic        i_rx_high_ber,
   input  logic        i_rx_bad_block,
   input  logic        i_err_block_count_clr,
   output logic        o_serdes_rx_reset_req,
   output logic        o_rx_status,
   output logic [2:0]  o_rx_link_state,
   output logic [7:0]  o_rx_reset_count
`ifdef ETH_PHY_RX_LINK_CTRL_ERR_CNT_EN
   ,
   output logic [15:0] o_err_block_count
`endif
);

   localparam int PW = $clog2(RESET_PULSE_CYCLES + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT_TICKS + 1);
   localparam int HW = $clog2(UP_HOLD_TICKS + 1);
   localparam logic [PW-1:0] PULSE_LAST   = PW'(RESET_PULSE_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_TICKS - 1);
   localparam logic [HW-1:0] HOLD_LAST    = HW'(UP_HOLD_TICKS - 1);

   linkState_t    r_state;
   logic          r_resetReq;
   logic          r_rxStatus;
   logic          r_reload;
   logic [PW-1:0] r_pulseCnt;
   logic [TW-1:0] r_timeoutCnt;
   logic [HW-1:0] r_holdCnt;
   logic [7:0]    r_resetCount;
   logic          w_tick;

   eth_phy_10g_tick_gen #(
      .COUNT(COUNT_125US)
   ) u_tickGen (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_reload(r_reload),
      .o_tick  (w_tick)
   );

   // r_reload is raised on every state change so the prescaler restarts each phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_DISABLED;
         r_resetReq   <= 1'b0;
         r_rxStatus   <= 1'b0;
         r_reload     <= 1'b0;
         r_pulseCnt   <= '0;
         r_timeoutCnt <= '0;
         r_holdCnt    <= '0;
         r_resetCount <= '0;
      end else begin
         r_reload <= 1'b0;
         if (!i_cfg_enable) begin
            if (r_state != ST_DISABLED) begin
               r_reload <= 1'b1;
            end
            r_state    <= ST_DISABLED;
            r_resetReq <= 1'b0;
            r_rxStatus <= 1'b0;
         end else begin
            case (r_state)
               ST_DISABLED: begin
                  r_state    <= ST_SERDES_RST;
                  r_resetReq <= 1'b1;
                  r_pulseCnt <= '0;
                  r_reload   <= 1'b1;
               end
               ST_SERDES_RST: begin
                  if (r_pulseCnt == PULSE_LAST) begin
                     r_state      <= ST_WAIT_LOCK;
                     r_resetReq   <= 1'b0;
                     r_timeoutCnt <= '0;
                     r_reload     <= 1'b1;
                  end else begin
                     r_pulseCnt <= r_pulseCnt + 1'b1;
                  end
               end
               ST_WAIT_LOCK: begin
                  if (i_rx_block_lock) begin
                     r_state   <= ST_WAIT_BER;
                     r_holdCnt <= '0;
                     r_reload  <= 1'b1;
                  end else if (w_tick) begin
                     if (r_timeoutCnt == TIMEOUT_LAST) begin
                        r_state    <= ST_SERDES_RST;
                        r_resetReq <= 1'b1;
                        r_pulseCnt <= '0;
                        r_reload   <= 1'b1;
                        if (r_resetCount != 8'hFF) begin
                           r_resetCount <= r_resetCount + 8'd1;
                        end
                     end else begin
                        r_timeoutCnt <= r_timeoutCnt + 1'b1;
                     end
                  end
               end
               ST_WAIT_BER: begin
                  if (!i_rx_block_lock) begin
                     r_state  <= ST_WAIT_LOCK;
                     r_reload <= 1'b1;
                  end else if (w_tick && (r_timeoutCnt == TIMEOUT_LAST)) begin
                     r_state    <= ST_SERDES_RST;
                     r_resetReq <= 1'b1;
                     r_pulseCnt <= '0;
                     r_reload   <= 1'b1;
                     if (r_resetCount != 8'hFF) begin
                        r_resetCount <= r_resetCount + 8'd1;
                     end
                  end else begin
                     if (w_tick) begin
                        r_timeoutCnt <= r_timeoutCnt + 1'b1;
                     end
                     if (i_rx_high_ber) begin
                        r_holdCnt <= '0;
                     end else if (w_tick) begin
                        if (r_holdCnt == HOLD_LAST) begin
                           r_state    <= ST_LINK_UP;
                           r_rxStatus <= 1'b1;
                           r_reload   <= 1'b1;
                        end else begin
                           r_holdCnt <= r_holdCnt + 1'b1;
                        end
                     end
                  end
               end
               ST_LINK_UP: begin
                  if (!i_rx_block_lock || i_rx_high_ber) begin
                     r_state      <= ST_WAIT_LOCK;
                     r_rxStatus   <= 1'b0;
                     r_timeoutCnt <= '0;
                     r_reload     <= 1'b1;
                  end
               end
               default: begin
                  r_state    <= ST_DISABLED;
                  r_resetReq <= 1'b0;
                  r_rxStatus <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_serdes_rx_reset_req = r_resetReq;
   assign o_rx_status           = r_rxStatus;
   assign o_rx_link_state       = r_state;
   assign o_rx_reset_count      = r_resetCount;

`ifdef ETH_PHY_RX_LINK_CTRL_ERR_CNT_EN
   logic [15:0] r_errCount;

   // Clear wins over a coincident errored block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_errCount <= '0;
      end else if (i_err_block_count_clr) begin
         r_errCount <= '0;
      end else if (i_rx_bad_block && (r_state == ST_LINK_UP) && (r_errCount != 16'hFFFF)) begin
         r_errCount <= r_errCount + 16'd1;
      end
   end

   assign o_err_block_count = r_errCount;
`else
   logic w_unusedErrInputs;
   assign w_unusedErrInputs = i_rx_bad_block ^ i_err_block_count_clr;
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_link_ctrl.sv
// Bench for eth_phy_10g_rx_link_ctrl: directed bring-up scenarios plus randomized
// stimulus against a phase-age based reference model.
module tb_eth_phy_10g_rx_link_ctrl;

   localparam int CNT = 10;
   localparam int RPC = 4;
   localparam int LT  = 5;
   localparam int UH  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cfgEnable = 1'b0;
   logic blockLock = 1'b0;
   logic highBer = 1'b0;
   logic badBlock = 1'b0;
   logic errClr = 1'b0;
   logic resetReq;
   logic rxStatus;
   logic [2:0] linkState;
   logic [7:0] resetCount;
`ifdef ETH_PHY_RX_LINK_CTRL_ERR_CNT_EN
   logic [15:0] errCount;
`endif

   int compared = 0;
   int mismatched = 0;
   int cycleNo = 0;

   // Reference model: spec state number, cycles spent in the current state,
   // timeout ticks, hold ticks, retry count and errored-block count.
   int mState, mAge, mTo, mHold, mRc, mErr;

   int n0, lat, rises, lastRise;
   logic prevReq;

   always #5 clk = ~clk;

   eth_phy_10g_rx_link_ctrl #(
      .COUNT_125US       (CNT),
      .RESET_PULSE_CYCLES(RPC),
      .LOCK_TIMEOUT_TICKS(LT),
      .UP_HOLD_TICKS     (UH)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .i_cfg_enable         (cfgEnable),
      .i_rx_block_lock      (blockLock),
      .i_rx_high_ber        (highBer),
      .i_rx_bad_block       (badBlock),
      .i_err_block_count_clr(errClr),
      .o_serdes_rx_reset_req(resetReq),
      .o_rx_status          (rxStatus),
      .o_rx_link_state      (linkState),
      .o_rx_reset_count     (resetCount)
`ifdef ETH_PHY_RX_LINK_CTRL_ERR_CNT_EN
      ,
      .o_err_block_count    (errCount)
`endif
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cycleNo, observed, expected);
      end
   endtask

   task automatic modelReset();
      mState = 0;
      mAge = 0;
      mTo = 0;
      mHold = 0;
      mRc = 0;
      mErr = 0;
   endtask

   task automatic checkModel();
      checkOutput("state", 32'(linkState), 32'(mState));
      checkOutput("resetReq", 32'(resetReq), 32'(mState == 1));
      checkOutput("rxStatus", 32'(rxStatus), 32'(mState == 4));
      checkOutput("resetCount", 32'(resetCount), 32'(mRc));
`ifdef ETH_PHY_RX_LINK_CTRL_ERR_CNT_EN
      checkOutput("errCount", 32'(errCount), 32'(mErr));
`endif
   endtask

   // Drive one cycle of inputs and advance the model to what the DUT should show after the next edge.
   task automatic applyStimulus(input logic en, input logic lock, input logic ber, input logic bad, input logic clr);
      int ns;
      bit tick;
      cfgEnable = en;
      blockLock = lock;
      highBer = ber;
      badBlock = bad;
      errClr = clr;
      tick = (mAge >= CNT) && ((mAge % CNT) == 0);
`ifdef ETH_PHY_RX_LINK_CTRL_ERR_CNT_EN
      if (clr) mErr = 0;
      else if (bad && mState == 4 && mErr < 65535) mErr++;
`endif
      ns = mState;
      if (!en) begin
         ns = 0;
      end else begin
         case (mState)
            0: ns = 1;
            1: if (mAge == RPC - 1) begin ns = 2; mTo = 0; end
            2: begin
               if (lock) begin
                  ns = 3;
                  mHold = 0;
               end else if (tick) begin
                  if (mTo + 1 >= LT) begin ns = 1; mRc = (mRc < 255) ? mRc + 1 : 255; end
                  else mTo++;
               end
            end
            3: begin
               if (!lock) begin
                  ns = 2;
               end else if (tick && (mTo + 1 >= LT)) begin
                  ns = 1;
                  mRc = (mRc < 255) ? mRc + 1 : 255;
               end else begin
                  if (tick) mTo++;
                  if (ber) mHold = 0;
                  else if (tick) begin
                     if (mHold + 1 >= UH) ns = 4;
                     else mHold++;
                  end
               end
            end
            4: if (!lock || ber) begin ns = 2; mTo = 0; end
            default: ns = 0;
         endcase
      end
      mAge = (ns == mState) ? mAge + 1 : 0;
      mState = ns;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
      cycleNo++;
      checkModel();
   endtask

   // Reset is asserted mid-cycle to exercise the asynchronous path.
   task automatic doReset();
      #2;
      rst_n = 1'b0;
      cfgEnable = 1'b0;
      blockLock = 1'b0;
      highBer = 1'b0;
      badBlock = 1'b0;
      errClr = 1'b0;
      modelReset();
      #1;
      checkModel();
      @(posedge clk);
      #1;
      cycleNo++;
      checkModel();
      rst_n = 1'b1;
   endtask

   initial begin
      modelReset();
      #1;
      checkModel();
      @(posedge clk);
      #1;
      checkModel();
      rst_n = 1'b1;

      // Lock never arrives: periodic SERDES resets with a counted retry each time.
      rises = 0;
      prevReq = 1'b0;
      lastRise = 0;
      for (int i = 0; i < 300 && rises < 4; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         stepCycle();
         if (resetReq && !prevReq) begin
            if (rises > 0) begin
               checkOutput("retryGap", 32'(cycleNo - lastRise), 32'(RPC + LT * CNT + 1));
               checkOutput("retryCount", 32'(resetCount), 32'(rises));
            end
            lastRise = cycleNo;
            rises++;
         end
         prevReq = resetReq;
      end
      checkOutput("retryRises", 32'(rises), 32'd4);

      // Clean lock: link-up latency from WAIT_BER entry, then a one-cycle lock drop.
      doReset();
      n0 = -1;
      for (int i = 0; i < 60 && n0 < 0; i++) begin
         applyStimulus(1, 1, 0, 0, 0);
         stepCycle();
         if (linkState == 3'd3) n0 = cycleNo;
      end
      checkOutput("berEntry", 32'(n0 >= 0), 32'd1);
      lat = -1;
      for (int i = 0; i < 100 && lat < 0; i++) begin
         applyStimulus(1, 1, 0, 0, 0);
         stepCycle();
         if (rxStatus) lat = cycleNo - n0;
      end
      checkOutput("upLatency", 32'(lat), 32'(UH * CNT + 1));
      checkOutput("upResetCount", 32'(resetCount), 32'd0);
      applyStimulus(1, 0, 0, 0, 0);
      stepCycle();
      checkOutput("dropStatus", 32'(rxStatus), 32'd0);
      checkOutput("dropState", 32'(linkState), 32'd2);
      applyStimulus(1, 1, 0, 0, 0);
      stepCycle();
      checkOutput("reacquireState", 32'(linkState), 32'd3);

      // High-BER glitch between the first and second tick restarts the hold.
      doReset();
      n0 = -1;
      for (int i = 0; i < 60 && n0 < 0; i++) begin
         applyStimulus(1, 1, 0, 0, 0);
         stepCycle();
         if (linkState == 3'd3) n0 = cycleNo;
      end
      lat = -1;
      for (int i = 0; i < 100 && lat < 0 && n0 >= 0; i++) begin
         applyStimulus(1, 1, (cycleNo - n0) == 15, 0, 0);
         stepCycle();
         if (rxStatus) lat = cycleNo - n0;
      end
      checkOutput("berGlitchLatency", 32'(lat), 32'(3 * CNT + 1));

      // Disable in the middle of the reset pulse.
      doReset();
      applyStimulus(1, 0, 0, 0, 0);
      stepCycle();
      applyStimulus(1, 0, 0, 0, 0);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0);
      stepCycle();
      checkOutput("disableReq", 32'(resetReq), 32'd0);
      checkOutput("disableState", 32'(linkState), 32'd0);

`ifdef ETH_PHY_RX_LINK_CTRL_ERR_CNT_EN
      // Errored-block counter saturation and clear priority.
      doReset();
      for (int i = 0; i < 100 && !rxStatus; i++) begin
         applyStimulus(1, 1, 0, 0, 0);
         stepCycle();
      end
      checkOutput("errLinkUp", 32'(rxStatus), 32'd1);
      for (int i = 0; i < 65600; i++) begin
         applyStimulus(1, 1, 0, 1, 0);
         stepCycle();
      end
      checkOutput("errSaturate", 32'(errCount), 32'd65535);
      applyStimulus(1, 1, 0, 1, 1);
      stepCycle();
      checkOutput("errClrPriority", 32'(errCount), 32'd0);
      applyStimulus(1, 1, 0, 1, 0);
      stepCycle();
      checkOutput("errAfterClr", 32'(errCount), 32'd1);
`endif

      // Randomized segments of differing lock/BER behaviour.
      doReset();
      for (int seg = 0; seg < 60; seg++) begin
         int mode;
         int len;
         logic en, lock, ber, bad, clr;
         mode = $urandom_range(0, 3);
         len = $urandom_range(20, 150);
         for (int c = 0; c < len; c++) begin
            en = ($urandom_range(0, 399) != 0);
            case (mode)
               0: begin lock = 1'b0; ber = 1'($urandom_range(0, 1)); end
               1: begin lock = 1'b1; ber = ($urandom_range(0, 49) == 0); end
               2: begin lock = ($urandom_range(0, 15) != 0); ber = ($urandom_range(0, 31) == 0); end
               default: begin lock = 1'($urandom_range(0, 1)); ber = 1'($urandom_range(0, 1)); end
            endcase
            bad = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 63) == 0);
            applyStimulus(en, lock, ber, bad, clr);
            stepCycle();
         end
         if (seg == 30) doReset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
